// File: rtl/single_float_pkg.sv
// Shared IEEE-754 single-precision helpers and FSM encoding for the max-stream reduction.
package single_float_pkg;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [7:0]  EXP_ONES  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [31:0] bits);
    return (bits[30:23] == EXP_ONES) && (bits[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key: -inf lowest, -0 just below +0, +inf highest.
  function automatic logic [31:0] order_key(input logic [31:0] bits);
    return bits[31] ? ~bits : (bits ^ 32'h80000000);
  endfunction

endpackage

// File: rtl/single_gt.sv
// Strict greater-than on single-precision values under the total ordering key.
module single_gt
  import single_float_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  // A NaN never wins, and any number beats a canonical NaN held as the running max.
  assign a_gt_b = !is_nan(a) && (is_nan(b) || (order_key(a) > order_key(b)));

endmodule

// File: rtl/single_max_stream.sv
// Framed running-maximum reduction: one (max, first index, count, overflow) result per frame.
module single_max_stream
  import single_float_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int IDX_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_a,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [31:0]       out_z,
  output logic [IDX_W-1:0]  out_index,
  output logic [IDX_W:0]    out_count,
  output logic              out_overflow,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(MAX_LEN - 1);
  localparam bit             ONE_LEN  = (MAX_LEN == 1);

  state_t           state_q;
  logic [31:0]      max_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   cnt_q;
  logic             ovf_q;
  logic             new_gt;
  logic             accept;

  single_gt u_gt (
    .a      (in_a),
    .b      (max_q),
    .a_gt_b (new_gt)
  );

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      max_q   <= 32'd0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // An all-NaN frame reports the canonical NaN at index 0.
            max_q   <= is_nan(in_a) ? CANON_NAN : in_a;
            idx_q   <= '0;
            cnt_q   <= (IDX_W+1)'(1);
            ovf_q   <= ONE_LEN && !in_last;
            state_q <= (in_last || ONE_LEN) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if (new_gt) begin
              max_q <= in_a;
              idx_q <= cnt_q[IDX_W-1:0];
            end
            cnt_q <= cnt_q + (IDX_W+1)'(1);
            if (in_last) begin
              ovf_q   <= 1'b0;
              state_q <= S_DONE;
            end else if (cnt_q == LAST_IDX) begin
              ovf_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = (state_q == S_DONE);
  assign out_z        = max_q;
  assign out_index    = idx_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_single_max_stream.sv
// Scoreboard bench for single_max_stream: directed frames plus randomized frames against a reference model.
module tb_single_max_stream;

  localparam int MAX_LEN = 1024;
  localparam int IDX_W   = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       in_a = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [31:0]       out_z;
  logic [IDX_W-1:0]  out_index;
  logic [IDX_W:0]    out_count;
  logic              out_overflow;
  logic              out_valid;
  logic              out_ready = 1'b0;

  single_max_stream #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_z(out_z), .out_index(out_index), .out_count(out_count),
    .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      z;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
    logic             ovf;
  } res_t;

  res_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rdy_mode = 1;   // 0 random, 1 hold low, 2 hold high
  bit   gaps = 1'b0;
  logic end_elem = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model, written from value semantics rather than the ordering key.
  function automatic bit f_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic bit f_greater(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic res_t model(input logic [31:0] e[$], input bit lastset);
    res_t r;
    bit   have = 0;
    r.z = 32'h7FC00000;
    r.idx = '0;
    for (int i = 0; i < e.size(); i++) begin
      if (!f_nan(e[i]) && (!have || f_greater(e[i], r.z))) begin
        r.z = e[i];
        r.idx = IDX_W'(i);
        have = 1;
      end
    end
    r.cnt = (IDX_W+1)'(e.size());
    r.ovf = !lastset;
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = {1'($urandom_range(0, 1)), 31'd0};
      1: v = {1'($urandom_range(0, 1)), 31'h7F800000};
      2: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      3: v = 32'h3F800000;
      4: v = 32'hBF800000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'($urandom_range(0, 1));
      1: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: samples at the falling edge, pops the scoreboard on each handshake.
  int   nneg = 0;
  int   pend = -1;
  bit   prev_v = 0;
  bit   prev_hs = 0;
  res_t prev_r;
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    nneg++;
    cur = '{z: out_z, idx: out_index, cnt: out_count, ovf: out_overflow};
    if (rst) begin
      prev_v = 0;
      prev_hs = 0;
      pend = -1;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid));
      if (out_valid && !prev_v) chk("latency", 64'(nneg), 64'(pend));
      if (out_valid && prev_v && !prev_hs) chk("stable", 64'(cur), 64'(prev_r));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_result", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("out_z", 64'(out_z), 64'(e.z));
          chk("out_index", 64'(out_index), 64'(e.idx));
          chk("out_count", 64'(out_count), 64'(e.cnt));
          chk("out_overflow", 64'(out_overflow), 64'(e.ovf));
        end
      end
      if (in_valid && in_ready && end_elem) pend = nneg + 1;
      prev_v = out_valid;
      prev_hs = out_valid && out_ready;
      prev_r = cur;
    end
  end

  // All driver tasks are entered one time unit after a rising edge.
  task automatic send_elem(input logic [31:0] v, input bit last, input bit endf);
    bit ok;
    int tmo;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_a = $urandom;
      in_last = 1'($urandom_range(0, 1));
      end_elem = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_a = v;
    in_last = last;
    end_elem = endf;
    tmo = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      tmo++;
    end while (!ok && tmo < 300);
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_frame(input logic [31:0] e[$], input bit lastset);
    for (int i = 0; i < e.size(); i++)
      send_elem(e[i], lastset && (i == e.size() - 1), i == e.size() - 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    end_elem = 1'b0;
    sb.push_back(model(e, lastset));
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_z", 64'(out_z), 64'(0));
    chk("rst_out_index", 64'(out_index), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_overflow", 64'(out_overflow), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] fr[$];
    int tmo;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    rdy_mode = 2;

    fr = '{32'h3F800000, 32'h40000000, 32'hC0400000};
    send_frame(fr, 1);
    fr = '{32'h80000000, 32'h00000000, 32'h00000000};
    send_frame(fr, 1);
    fr = '{32'h7FC00000, 32'hFF800000, 32'h7FC00001};
    send_frame(fr, 1);
    fr = '{32'h7FC00000, 32'h7FA00000};
    send_frame(fr, 1);

    // Backpressure: result held while the next frame is already presented.
    rdy_mode = 1;
    fr = '{32'h41200000, 32'hC1200000};
    send_frame(fr, 1);
    fr = '{32'h3F000000, 32'h3F400000};
    fork
      send_frame(fr, 1);
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 2;
      end
    join

    // Forced termination at MAX_LEN.
    fr.delete();
    for (int i = 0; i < MAX_LEN; i++)
      fr.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)});
    fr[700] = 32'h7F800000;
    send_frame(fr, 0);

    // Reset mid-frame discards the partial frame.
    send_elem(32'h40400000, 0, 0);
    send_elem(32'h40800000, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset();
    rst = 1'b0;
    fr = '{32'h3F800000};
    send_frame(fr, 1);

    // Randomized frames with gaps and random backpressure.
    gaps = 1'b1;
    rdy_mode = 0;
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      for (int i = 0, n = $urandom_range(1, 16); i < n; i++) begin
        if (i > 0 && $urandom_range(0, 5) == 0) fr.push_back(fr[$urandom_range(0, i - 1)]);
        else fr.push_back(rnd_val());
      end
      send_frame(fr, 1);
    end

    rdy_mode = 2;
    tmo = 0;
    while (sb.size() != 0 && tmo < 100) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/single_max_stream.md
Name: single_max_stream

Overview:
- Downstream reduction stage for the single-precision max datapath.
- Consumes a framed stream of IEEE-754 single values and keeps a running maximum with its position.
- Emits one result per frame: max value, index of the first occurrence, and element count.
- Sits after the pairwise max/compare components and feeds result consumers through a valid/ready handshake.

Parameters:
- MAX_LEN, 1024, maximum elements per frame; a frame is force-terminated at this length.
- IDX_W, 10, width of index/count fields; must satisfy 2**IDX_W >= MAX_LEN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_a  in  32  IEEE-754 single input element.
- in_valid  in  1  in_a is valid.
- in_last  in  1  marks the final element of a frame.
- in_ready  out  1  block accepts an element this cycle.
- out_z  out  32  frame maximum.
- out_index  out  IDX_W  index of first occurrence of the maximum, 0-based.
- out_count  out  IDX_W+1  number of elements in the frame.
- out_overflow  out  1  frame was force-terminated at MAX_LEN.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: state IDLE; out_valid=0, out_z=0, out_index=0, out_count=0, out_overflow=0; in_ready=1 from the first cycle after reset.
- Reset mid-frame or mid-DONE discards the partial frame or pending result; nothing is emitted for it.
- Accept rule: an element is accepted on a cycle where in_valid && in_ready.
- in_ready = (state != DONE). This gives one bubble per frame and is accepted by design.
- States:
  - IDLE: no element accepted yet. On accept, load the element as the max, index=0, count=1, go to ACCUM. If in_last is also set, go directly to DONE.
  - ACCUM: on accept, update per the ordering rule and increment count. Go to DONE on in_last, or when the accepted element has index MAX_LEN-1 (forced end; out_overflow=1 unless in_last was also set on that element).
  - DONE: out_valid=1 and all outputs held stable. On out_ready, clear out_valid and go to IDLE.
- Latency: out_valid rises in the cycle after the last element is accepted.
- Ordering rule:
  - Non-NaN values compare via a 32-bit unsigned key: key = sign ? ~bits : bits ^ 32'h80000000.
  - This places -0 below +0 and -inf/+inf at the extremes.
  - Replace the running max only if key(new) > key(current), strictly. Ties keep the earlier index.
- NaN handling (exponent all ones, mantissa nonzero):
  - NaN elements are counted but never become the max.
  - If every element of the frame is NaN, out_z=32'h7FC00000 and out_index=0.
  - A non-NaN arriving after only NaNs becomes the max with its own index.
- Inputs are ignored while in_valid=0, in every state.

Decomposition:
- Package single_float_pkg holds:
  - CANON_NAN = 32'h7FC00000
  - EXP_ONES = 8'hFF
  - function is_nan(bits)
  - function order_key(bits)
- One natural sub-module: single_gt, combinational, with inputs a, b and output a_gt_b per the ordering rule. The FSM instantiates it once against the running max.

Test Plan:
- Frame 3F800000, 40000000, C0400000 (last on third) -> out_z=40000000, out_index=1, out_count=3, out_valid exactly 1 cycle after the last accept.
- Frame 80000000, 00000000, 00000000 -> out_z=00000000, out_index=1 (+0 beats -0, tie keeps first).
- Frame 7FC00000, FF800000, 7FC00001 -> out_z=FF800000, out_index=1, out_count=3; frame of 7FC00000, 7FA00000 -> out_z=7FC00000, out_index=0.
- Hold out_ready=0 for 5 cycles after DONE with in_valid=1 -> in_ready=0 and outputs stable throughout; on out_ready=1, next frame accepted starting the following cycle.
- Send MAX_LEN elements with in_last never set, max 7F800000 at index 700 -> out_index=700, out_count=MAX_LEN, out_overflow=1.
- Assert rst for 1 cycle after 2 elements of a frame -> no result emitted; next frame 3F800000 (last) -> out_z=3F800000, out_count=1.
